// File: rtl/pong_game_ctrl.sv
// rtl/pong_game_ctrl.sv - pong game sequencer: serve, paddles, ball motion, scoring
module pong_game_ctrl #(
   parameter int ACTIVE_COLS  = 640,
   parameter int ACTIVE_ROWS  = 480,
   parameter int BALL_SIZE    = 8,
   parameter int PADDLE_W     = 8,
   parameter int PADDLE_H     = 64,
   parameter int PADDLE1_X    = 16,
   parameter int PADDLE2_X    = 616,
   parameter int BALL_SPEED   = 2,
   parameter int PADDLE_SPEED = 4,
   parameter int SERVE_FRAMES = 60,
   parameter int WIN_SCORE    = 9
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_tick,
   input  logic       start,
   input  logic       p1_up,
   input  logic       p1_down,
   input  logic       p2_up,
   input  logic       p2_down,
   output logic [9:0] ball_x,
   output logic [9:0] ball_y,
   output logic [9:0] paddle1_y,
   output logic [9:0] paddle2_y,
   output logic [3:0] score1,
   output logic [3:0] score2,
   output logic [1:0] state,
   output logic       game_over
);
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SERVE = 2'd1,
      ST_PLAY  = 2'd2,
      ST_OVER  = 2'd3
   } state_t;

   localparam int CW = (SERVE_FRAMES < 2) ? 1 : $clog2(SERVE_FRAMES + 1);

   // 12-bit working width keeps every sum of position plus size free of overflow
   localparam logic [11:0] L_COLS = 12'(ACTIVE_COLS);
   localparam logic [11:0] L_ROWS = 12'(ACTIVE_ROWS);
   localparam logic [11:0] L_BS   = 12'(BALL_SIZE);
   localparam logic [11:0] L_PH   = 12'(PADDLE_H);
   localparam logic [11:0] L_BSPD = 12'(BALL_SPEED);
   localparam logic [11:0] L_PSPD = 12'(PADDLE_SPEED);
   localparam logic [11:0] L_P1F  = 12'(PADDLE1_X + PADDLE_W);
   localparam logic [11:0] L_P2X  = 12'(PADDLE2_X);
   localparam logic [9:0]  CX     = 10'((ACTIVE_COLS - BALL_SIZE) / 2);
   localparam logic [9:0]  CY     = 10'((ACTIVE_ROWS - BALL_SIZE) / 2);
   localparam logic [9:0]  PC     = 10'((ACTIVE_ROWS - PADDLE_H) / 2);
   localparam logic [CW-1:0] L_SERVE = CW'(SERVE_FRAMES);
   localparam logic [3:0]  L_WIN  = 4'(WIN_SCORE);

   state_t        r_state;
   logic [9:0]    r_ball_x, r_ball_y, r_pad1, r_pad2;
   logic [3:0]    r_score1, r_score2;
   logic          r_dx, r_dy, r_game_over;
   logic [CW-1:0] r_cnt;

   logic [11:0] w_bx, w_by, w_py1, w_py2;
   logic [9:0]  w_pad1_nxt, w_pad2_nxt, w_bx_nxt, w_by_nxt;
   logic        w_dx_nxt, w_dy_nxt, w_ov1, w_ov2, w_miss_l, w_miss_r;
   logic [3:0]  w_s1_inc, w_s2_inc;

   function automatic logic [9:0] f_paddle_step(input logic [9:0] y, input logic up, input logic dn);
      logic [11:0] w_y;
      w_y = {2'b00, y};
      f_paddle_step = y;
      if (up && !dn)
         f_paddle_step = (w_y < L_PSPD) ? 10'd0 : 10'(w_y - L_PSPD);
      else if (dn && !up)
         f_paddle_step = (w_y + L_PH + L_PSPD > L_ROWS) ? 10'(L_ROWS - L_PH) : 10'(w_y + L_PSPD);
   endfunction

   assign w_bx  = {2'b00, r_ball_x};
   assign w_by  = {2'b00, r_ball_y};
   assign w_py1 = {2'b00, r_pad1};
   assign w_py2 = {2'b00, r_pad2};

   assign w_pad1_nxt = f_paddle_step(r_pad1, p1_up, p1_down);
   assign w_pad2_nxt = f_paddle_step(r_pad2, p2_up, p2_down);

   assign w_ov1 = (w_by + L_BS > w_py1) && (w_by < w_py1 + L_PH);
   assign w_ov2 = (w_by + L_BS > w_py2) && (w_by < w_py2 + L_PH);

   assign w_s1_inc = r_score1 + 4'd1;
   assign w_s2_inc = r_score2 + 4'd1;

   always_comb begin
      w_by_nxt = 10'(r_dy ? (w_by + L_BSPD) : (w_by - L_BSPD));
      w_dy_nxt = r_dy;
      if (!r_dy && w_by < L_BSPD) begin
         w_by_nxt = 10'd0;
         w_dy_nxt = 1'b1;
      end else if (r_dy && w_by + L_BS + L_BSPD > L_ROWS) begin
         w_by_nxt = 10'(L_ROWS - L_BS);
         w_dy_nxt = 1'b0;
      end
   end

   // paddle hits take precedence over misses so a ball grazing a face is returned
   always_comb begin
      w_bx_nxt = 10'(r_dx ? (w_bx + L_BSPD) : (w_bx - L_BSPD));
      w_dx_nxt = r_dx;
      w_miss_l = 1'b0;
      w_miss_r = 1'b0;
      if (!r_dx && w_bx >= L_P1F && w_bx <= L_P1F + L_BSPD && w_ov1) begin
         w_bx_nxt = 10'(L_P1F);
         w_dx_nxt = 1'b1;
      end else if (r_dx && w_bx + L_BS <= L_P2X && w_bx + L_BS + L_BSPD >= L_P2X && w_ov2) begin
         w_bx_nxt = 10'(L_P2X - L_BS);
         w_dx_nxt = 1'b0;
      end else if (!r_dx && w_bx < L_BSPD) begin
         w_miss_l = 1'b1;
      end else if (r_dx && w_bx + L_BS + L_BSPD >= L_COLS) begin
         w_miss_r = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_ball_x    <= CX;
         r_ball_y    <= CY;
         r_pad1      <= PC;
         r_pad2      <= PC;
         r_score1    <= 4'd0;
         r_score2    <= 4'd0;
         r_dx        <= 1'b1;
         r_dy        <= 1'b1;
         r_cnt       <= '0;
         r_game_over <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE, ST_OVER: begin
               if (start) begin
                  r_score1    <= 4'd0;
                  r_score2    <= 4'd0;
                  r_ball_x    <= CX;
                  r_ball_y    <= CY;
                  r_pad1      <= PC;
                  r_pad2      <= PC;
                  r_cnt       <= L_SERVE;
                  r_game_over <= 1'b0;
                  r_state     <= ST_SERVE;
               end
            end
            ST_SERVE: begin
               if (frame_tick) begin
                  r_pad1 <= w_pad1_nxt;
                  r_pad2 <= w_pad2_nxt;
                  if (r_cnt == CW'(1))
                     r_state <= ST_PLAY;
                  else
                     r_cnt <= r_cnt - CW'(1);
               end
            end
            ST_PLAY: begin
               if (frame_tick) begin
                  r_pad1 <= w_pad1_nxt;
                  r_pad2 <= w_pad2_nxt;
                  if (w_miss_l || w_miss_r) begin
                     // re-serve toward whoever conceded; vertical direction carries over
                     r_ball_x <= CX;
                     r_ball_y <= CY;
                     r_dx     <= w_miss_r;
                     if (w_miss_l)
                        r_score2 <= w_s2_inc;
                     else
                        r_score1 <= w_s1_inc;
                     if ((w_miss_l && w_s2_inc == L_WIN) || (w_miss_r && w_s1_inc == L_WIN)) begin
                        r_state     <= ST_OVER;
                        r_game_over <= 1'b1;
                     end else begin
                        r_cnt   <= L_SERVE;
                        r_state <= ST_SERVE;
                     end
                  end else begin
                     r_ball_x <= w_bx_nxt;
                     r_ball_y <= w_by_nxt;
                     r_dx     <= w_dx_nxt;
                     r_dy     <= w_dy_nxt;
                  end
               end
            end
         endcase
      end
   end

   assign ball_x    = r_ball_x;
   assign ball_y    = r_ball_y;
   assign paddle1_y = r_pad1;
   assign paddle2_y = r_pad2;
   assign score1    = r_score1;
   assign score2    = r_score2;
   assign state     = r_state;
   assign game_over = r_game_over;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb/tb_pong_game_ctrl.sv - directed and randomized checks of pong_game_ctrl against a frame-level model
module tb_pong_game_ctrl;
   localparam int COLS = 640, ROWS = 480, BS = 8, PW = 8, PH = 64;
   localparam int P1X = 16, P2X = 616, BSP = 2, PSP = 4, SF = 4, WIN = 2;
   localparam int CX = 316, CY = 236, PC = 208;
   localparam logic [50:0] RESET_VEC = {10'd316, 10'd236, 10'd208, 10'd208, 4'd0, 4'd0, 2'd0, 1'b0};

   logic clk = 1'b0, rst = 1'b0, frame_tick = 1'b0, start = 1'b0;
   logic p1_up = 1'b0, p1_down = 1'b0, p2_up = 1'b0, p2_down = 1'b0;
   logic [9:0] ball_x, ball_y, paddle1_y, paddle2_y;
   logic [3:0] score1, score2;
   logic [1:0] state;
   logic       game_over;

   int n_cmp = 0, n_fail = 0;
   int m_bx, m_by, m_p1, m_p2, m_s1, m_s2, m_st, m_cnt, m_dx, m_dy;

   pong_game_ctrl #(.SERVE_FRAMES(SF), .WIN_SCORE(WIN)) dut (
      .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start),
      .p1_up(p1_up), .p1_down(p1_down), .p2_up(p2_up), .p2_down(p2_down),
      .ball_x(ball_x), .ball_y(ball_y), .paddle1_y(paddle1_y), .paddle2_y(paddle2_y),
      .score1(score1), .score2(score2), .state(state), .game_over(game_over)
   );

   always #5 clk = ~clk;

   function automatic logic [50:0] dut_vec();
      return {ball_x, ball_y, paddle1_y, paddle2_y, score1, score2, state, game_over};
   endfunction

   function automatic logic [50:0] mdl_vec();
      return {10'(m_bx), 10'(m_by), 10'(m_p1), 10'(m_p2), 4'(m_s1), 4'(m_s2), 2'(m_st), 1'(m_st == 3)};
   endfunction

   function automatic string show(input logic [50:0] v);
      return $sformatf("ball=(%0d,%0d) pad=%0d/%0d score=%0d/%0d state=%0d over=%0d",
                       v[50:41], v[40:31], v[30:21], v[20:11], v[10:7], v[6:3], v[2:1], v[0]);
   endfunction

   task automatic m_reset();
      m_bx = CX; m_by = CY; m_p1 = PC; m_p2 = PC;
      m_s1 = 0; m_s2 = 0; m_st = 0; m_cnt = 0; m_dx = 1; m_dy = 1;
   endtask

   function automatic int paddle_move(input int y, input bit up, input bit dn);
      if (up && !dn) return (y - PSP < 0) ? 0 : y - PSP;
      if (dn && !up) return (y + PSP > ROWS - PH) ? ROWS - PH : y + PSP;
      return y;
   endfunction

   task automatic m_step(input bit tick, input bit go, input bit u1, input bit d1, input bit u2, input bit d2);
      int nx, ny, ndx, ndy, scorer, f1;
      bit ov1, ov2;
      if ((m_st == 0 || m_st == 3) && go) begin
         m_s1 = 0; m_s2 = 0; m_bx = CX; m_by = CY; m_p1 = PC; m_p2 = PC;
         m_cnt = SF; m_st = 1;
         return;
      end
      if (!tick) return;
      if (m_st == 1) begin
         m_p1 = paddle_move(m_p1, u1, d1);
         m_p2 = paddle_move(m_p2, u2, d2);
         if (m_cnt == 1) m_st = 2; else m_cnt--;
      end else if (m_st == 2) begin
         f1  = P1X + PW;
         ov1 = (m_by + BS > m_p1) && (m_by < m_p1 + PH);
         ov2 = (m_by + BS > m_p2) && (m_by < m_p2 + PH);
         ny = m_by + BSP * m_dy; ndy = m_dy;
         if (ny < 0) begin ny = 0; ndy = 1; end
         else if (ny + BS > ROWS) begin ny = ROWS - BS; ndy = -1; end
         nx = m_bx + BSP * m_dx; ndx = m_dx; scorer = 0;
         if (m_dx < 0 && m_bx >= f1 && m_bx - BSP <= f1 && ov1) begin nx = f1; ndx = 1; end
         else if (m_dx > 0 && m_bx + BS <= P2X && m_bx + BS + BSP >= P2X && ov2) begin nx = P2X - BS; ndx = -1; end
         else if (m_dx < 0 && m_bx < BSP) scorer = 2;
         else if (m_dx > 0 && m_bx + BS + BSP >= COLS) scorer = 1;
         m_p1 = paddle_move(m_p1, u1, d1);
         m_p2 = paddle_move(m_p2, u2, d2);
         if (scorer == 0) begin
            m_bx = nx; m_by = ny; m_dx = ndx; m_dy = ndy;
         end else begin
            m_bx = CX; m_by = CY;
            if (scorer == 1) begin m_s1++; m_dx = 1; end
            else begin m_s2++; m_dx = -1; end
            if (m_s1 == WIN || m_s2 == WIN) m_st = 3;
            else begin m_cnt = SF; m_st = 1; end
         end
      end
   endtask

   task automatic drive(input bit tick, input bit go, input bit u1, input bit d1, input bit u2, input bit d2);
      @(negedge clk);
      frame_tick = tick; start = go;
      p1_up = u1; p1_down = d1; p2_up = u2; p2_down = d2;
      @(posedge clk);
      m_step(tick, go, u1, d1, u2, d2);
      @(negedge clk);
      frame_tick = 1'b0; start = 1'b0;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      #2;
      rst = 1'b1;
      m_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      #1 rst = 1'b1;
      #2;
      n_cmp++;
      if (dut_vec() !== RESET_VEC) begin
         n_fail++; $display("FAIL reset_power_on: got %s want %s", show(dut_vec()), show(RESET_VEC));
      end
      @(negedge clk);
      rst = 1'b0;
      drive(0, 1, 0, 0, 0, 0);
      for (int i = 0; i < SF + 10; i++) drive(1, 0, 0, 1, 1, 0);
      n_cmp++;
      if (state !== 2'd2) begin
         n_fail++; $display("FAIL reset_reach_play: got state %0d want 2", state);
      end
      @(negedge clk);
      #2;
      rst = 1'b1;
      m_reset();
      #1;
      n_cmp++;
      if (dut_vec() !== RESET_VEC) begin
         n_fail++; $display("FAIL reset_async: got %s want %s", show(dut_vec()), show(RESET_VEC));
      end
      @(negedge clk);
      rst = 1'b0;
      drive(1, 0, 1, 0, 1, 0);
      n_cmp++;
      if (dut_vec() !== mdl_vec()) begin
         n_fail++; $display("FAIL reset_tick_in_idle: got %s want %s", show(dut_vec()), show(mdl_vec()));
      end
   endtask

   task automatic test_serve();
      logic [1:0] exp_st;
      pulse_reset();
      drive(0, 1, 0, 0, 0, 0);
      n_cmp++;
      if (state !== 2'd1) begin
         n_fail++; $display("FAIL serve_enter: got state %0d want 1", state);
      end
      for (int i = 1; i <= SF; i++) begin
         drive(1, 0, 0, 0, 0, 0);
         exp_st = (i == SF) ? 2'd2 : 2'd1;
         n_cmp++;
         if (state !== exp_st) begin
            n_fail++; $display("FAIL serve_count tick %0d: got state %0d want %0d", i, state, exp_st);
         end
      end
      drive(1, 0, 0, 0, 0, 0);
      n_cmp++;
      if (ball_x !== 10'd318 || ball_y !== 10'd238) begin
         n_fail++; $display("FAIL serve_first_move: got (%0d,%0d) want (318,238)", ball_x, ball_y);
      end
   endtask

   task automatic test_back_to_back();
      logic [1:0] exp_st;
      pulse_reset();
      drive(1, 1, 0, 0, 0, 0);
      for (int i = 1; i <= SF; i++) begin
         drive(1, 0, 0, 0, 0, 0);
         exp_st = (i == SF) ? 2'd2 : 2'd1;
         n_cmp++;
         if (state !== exp_st || dut_vec() !== mdl_vec()) begin
            n_fail++; $display("FAIL start_with_tick %0d: got %s want %s", i, show(dut_vec()), show(mdl_vec()));
         end
      end
   endtask

   task automatic test_paddle_clamp();
      pulse_reset();
      drive(0, 1, 0, 0, 0, 0);
      for (int i = 1; i <= 60; i++) begin
         drive(1, 0, 1, 0, 0, 1);
         n_cmp++;
         if (dut_vec() !== mdl_vec()) begin
            n_fail++; $display("FAIL clamp_track %0d: got %s want %s", i, show(dut_vec()), show(mdl_vec()));
         end
         if (i == 52 || i == 60) begin
            n_cmp++;
            if (paddle1_y !== 10'd0 || paddle2_y !== 10'd416) begin
               n_fail++; $display("FAIL clamp_edges %0d: got %0d/%0d want 0/416", i, paddle1_y, paddle2_y);
            end
         end
      end
      for (int i = 0; i < 10; i++) drive(1, 0, 0, 1, 1, 0);
      for (int i = 0; i < 5; i++) begin
         drive(1, 0, 1, 1, 1, 1);
         n_cmp++;
         if (paddle1_y !== 10'd40 || paddle2_y !== 10'd376) begin
            n_fail++; $display("FAIL clamp_both_pressed: got %0d/%0d want 40/376", paddle1_y, paddle2_y);
         end
      end
   endtask

   task automatic test_wall_bounce();
      logic [9:0] exp_y;
      pulse_reset();
      drive(0, 1, 0, 0, 0, 0);
      for (int i = 0; i < SF; i++) drive(1, 0, 0, 0, 0, 0);
      for (int t = 1; t <= 120; t++) begin
         drive(1, 0, 0, 0, 0, 0);
         n_cmp++;
         if (dut_vec() !== mdl_vec()) begin
            n_fail++; $display("FAIL wall_track %0d: got %s want %s", t, show(dut_vec()), show(mdl_vec()));
         end
         if (t >= 118) begin
            exp_y = (t == 120) ? 10'd470 : 10'd472;
            n_cmp++;
            if (ball_y !== exp_y) begin
               n_fail++; $display("FAIL wall_bounce tick %0d: got y=%0d want %0d", t, ball_y, exp_y);
            end
         end
      end
   endtask

   task automatic test_paddle_hit();
      pulse_reset();
      drive(0, 1, 0, 0, 0, 0);
      for (int i = 0; i < SF; i++) drive(1, 0, 0, 0, 0, 0);
      for (int t = 1; t <= 147; t++) begin
         drive(1, 0, 0, 0, 0, t <= 40);
         n_cmp++;
         if (dut_vec() !== mdl_vec()) begin
            n_fail++; $display("FAIL hit_track %0d: got %s want %s", t, show(dut_vec()), show(mdl_vec()));
         end
         if (t == 40) begin
            n_cmp++;
            if (paddle2_y !== 10'd368) begin
               n_fail++; $display("FAIL hit_paddle_pos: got %0d want 368", paddle2_y);
            end
         end
         if (t == 145) begin
            n_cmp++;
            if (ball_x !== 10'd606 || ball_y !== 10'd420) begin
               n_fail++; $display("FAIL hit_approach: got (%0d,%0d) want (606,420)", ball_x, ball_y);
            end
         end
         if (t == 146 || t == 147) begin
            n_cmp++;
            if (ball_x !== ((t == 146) ? 10'd608 : 10'd606)) begin
               n_fail++; $display("FAIL hit_return tick %0d: got x=%0d want %0d", t, ball_x, (t == 146) ? 608 : 606);
            end
         end
      end
   endtask

   task automatic test_miss_and_win();
      int k;
      pulse_reset();
      drive(0, 1, 0, 0, 0, 0);
      k = 0;
      while (m_s1 < 1 && k < 400) begin
         drive(1, 0, 0, 0, 0, 0);
         k++;
         n_cmp++;
         if (dut_vec() !== mdl_vec()) begin
            n_fail++; $display("FAIL miss_track %0d: got %s want %s", k, show(dut_vec()), show(mdl_vec()));
         end
      end
      n_cmp++;
      if (k >= 400 || score1 !== 4'd1 || state !== 2'd1 || ball_x !== 10'd316 || ball_y !== 10'd236) begin
         n_fail++; $display("FAIL first_miss: got %s want score1=1 state=1 ball=(316,236)", show(dut_vec()));
      end
      k = 0;
      while (m_st != 3 && k < 600) begin
         drive(1, 0, 0, 0, 0, 0);
         k++;
         n_cmp++;
         if (dut_vec() !== mdl_vec()) begin
            n_fail++; $display("FAIL win_track %0d: got %s want %s", k, show(dut_vec()), show(mdl_vec()));
         end
      end
      n_cmp++;
      if (k >= 600 || score1 !== 4'd2 || state !== 2'd3 || game_over !== 1'b1) begin
         n_fail++; $display("FAIL win_detect: got %s want score1=2 state=3 over=1", show(dut_vec()));
      end
      for (int i = 0; i < 3; i++) drive(1, 0, 1, 0, 0, 1);
      n_cmp++;
      if (dut_vec() !== mdl_vec()) begin
         n_fail++; $display("FAIL over_frozen: got %s want %s", show(dut_vec()), show(mdl_vec()));
      end
      drive(0, 1, 0, 0, 0, 0);
      n_cmp++;
      if (score1 !== 4'd0 || score2 !== 4'd0 || state !== 2'd1 || game_over !== 1'b0) begin
         n_fail++; $display("FAIL restart: got %s want score=0/0 state=1 over=0", show(dut_vec()));
      end
   endtask

   task automatic test_random();
      pulse_reset();
      for (int i = 0; i < 4000; i++) begin
         bit tk, go, u1, d1, u2, d2;
         tk = ($urandom_range(3) != 0);
         go = ($urandom_range(15) == 0);
         if ($urandom_range(1) == 0) begin
            u1 = (m_by + 4 < m_p1 + 28); d1 = (m_by + 4 > m_p1 + 36);
            u2 = (m_by + 4 < m_p2 + 28); d2 = (m_by + 4 > m_p2 + 36);
         end else begin
            u1 = 1'($urandom); d1 = 1'($urandom); u2 = 1'($urandom); d2 = 1'($urandom);
         end
         if ($urandom_range(999) == 0) begin
            pulse_reset();
            n_cmp++;
            if (dut_vec() !== RESET_VEC) begin
               n_fail++; $display("FAIL random_reset %0d: got %s want %s", i, show(dut_vec()), show(RESET_VEC));
            end
         end else begin
            drive(tk, go, u1, d1, u2, d2);
            n_cmp++;
            if (dut_vec() !== mdl_vec()) begin
               n_fail++; $display("FAIL random %0d: got %s want %s", i, show(dut_vec()), show(mdl_vec()));
            end
         end
      end
   endtask

   initial begin
      m_reset();
      test_reset();
      test_serve();
      test_back_to_back();
      test_paddle_clamp();
      test_wall_bounce();
      test_paddle_hit();
      test_miss_and_win();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: bench still running at time %0t, limit 2000000", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
